sprite_compositor: RTL

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

---
 rtl/sprite_pkg.sv | 9 +
 rtl/sprite_addr_gen.sv | 28 ++
 rtl/sprite_compositor.sv | 117 +++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and colour defaults for the sprite compositor.
package sprite_pkg;
    typedef logic [23:0] rgb_t;
    typedef logic [9:0]  coord_t;
    typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} blink_state_t;

    localparam rgb_t KEY_RGB_DEFAULT = 24'hFF0000;
    localparam rgb_t BG_RGB_DEFAULT  = 24'hB7FE7B;
endpackage

// File: rtl/sprite_addr_gen.sv
// Per-layer sprite ROM address generator and compositing-active flag.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int unsigned ADDR_W = 19
) (
    input  coord_t            draw_x_i,
    input  coord_t            draw_y_i,
    input  coord_t            origin_x_i,
    input  coord_t            origin_y_i,
    input  logic [3:0]        stride_log2_i,
    input  logic              hit_i,
    input  logic              en_i,
    input  logic              blink_i,
    input  logic              blink_phase_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              active_o
);
    logic [ADDR_W-1:0] dx;
    logic [ADDR_W-1:0] dy;

    always_comb begin
        dx = ADDR_W'(draw_x_i) - ADDR_W'(origin_x_i);
        dy = ADDR_W'(draw_y_i) - ADDR_W'(origin_y_i);
        rom_addr_o = hit_i ? (dx + (dy << stride_log2_i)) : '0;
        active_o   = hit_i & en_i & (~blink_i | blink_phase_i);
    end
endmodule

// File: rtl/sprite_compositor.sv
// Multi-layer sprite compositor: per-layer ROM addressing, priority/colour-key
// selection and frame-based blinking, with a fixed ROM_LAT+1 cycle latency.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned ADDR_W     = 19,
    parameter rgb_t        KEY_RGB    = KEY_RGB_DEFAULT,
    parameter rgb_t        BG_RGB     = BG_RGB_DEFAULT,
    parameter int unsigned BLINK_LOG2 = 5
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             frame_start,
    input  logic                             pix_valid,
    input  coord_t                           DrawX,
    input  coord_t                           DrawY,
    input  logic [NUM_LAYERS-1:0]            layer_en,
    input  logic [NUM_LAYERS-1:0]            layer_blink,
    input  logic [NUM_LAYERS-1:0]            layer_hit,
    input  coord_t [NUM_LAYERS-1:0]          originX,
    input  coord_t [NUM_LAYERS-1:0]          originY,
    input  logic [NUM_LAYERS-1:0][3:0]       stride_log2,
    output logic [NUM_LAYERS-1:0][ADDR_W-1:0] rom_addr,
    input  rgb_t [NUM_LAYERS-1:0]            rom_data,
    output logic [7:0]                       VGA_R,
    output logic [7:0]                       VGA_G,
    output logic [7:0]                       VGA_B,
    output logic                             out_valid
);
    logic [BLINK_LOG2:0]   frame_cnt_q, frame_cnt_d;
    blink_state_t          state_q, state_d;
    logic                  blink_phase;
    logic [NUM_LAYERS-1:0] active;
    logic [NUM_LAYERS-1:0] act_q [ROM_LAT];
    logic                  pv_q  [ROM_LAT];
    rgb_t                  sel_rgb;
    logic                  found;

    // Phase only moves on frame_start, so a pixel coincident with it uses the old phase.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        state_d     = state_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            state_d     = frame_cnt_d[BLINK_LOG2] ? HIDE : SHOW;
        end
    end

    assign blink_phase = (state_q == SHOW);

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        sprite_addr_gen #(
            .ADDR_W(ADDR_W)
        ) u_addr_gen (
            .draw_x_i      (DrawX),
            .draw_y_i      (DrawY),
            .origin_x_i    (originX[g]),
            .origin_y_i    (originY[g]),
            .stride_log2_i (stride_log2[g]),
            .hit_i         (layer_hit[g]),
            .en_i          (layer_en[g]),
            .blink_i       (layer_blink[g]),
            .blink_phase_i (blink_phase),
            .rom_addr_o    (rom_addr[g]),
            .active_o      (active[g])
        );
    end

    // Lowest-index active, non-keyed layer wins; otherwise background.
    always_comb begin
        sel_rgb = BG_RGB;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!found && act_q[ROM_LAT-1][i] && (rom_data[i] != KEY_RGB)) begin
                sel_rgb = rom_data[i];
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int unsigned s = 0; s < ROM_LAT; s++) begin
                act_q[s] <= '0;
                pv_q[s]  <= 1'b0;
            end
            frame_cnt_q <= '0;
            state_q     <= SHOW;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            out_valid   <= 1'b0;
        end else begin
            act_q[0] <= active;
            pv_q[0]  <= pix_valid;
            for (int unsigned s = 1; s < ROM_LAT; s++) begin
                act_q[s] <= act_q[s-1];
                pv_q[s]  <= pv_q[s-1];
            end
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            if (pv_q[ROM_LAT-1]) begin
                VGA_R     <= sel_rgb[23:16];
                VGA_G     <= sel_rgb[15:8];
                VGA_B     <= sel_rgb[7:0];
                out_valid <= 1'b1;
            end else begin
                VGA_R     <= '0;
                VGA_G     <= '0;
                VGA_B     <= '0;
                out_valid <= 1'b0;
            end
        end
    end
endmodule
